// File: rtl/seq_array_multiplier.sv
// Iterative shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product,
// one multiplier bit per clock. Signed operands are reduced to magnitudes on
// entry and the sign is reapplied when the product is written out.
module seq_array_multiplier #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_m_q, mag_m_d;
    logic                 neg_q, neg_d;
    // Upper WIDTH+1 bits hold the partial sum; the low WIDTH bits start out
    // holding |q| and are shifted out one multiplier bit per iteration.
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_q_in;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     added;
    logic [2*WIDTH-1:0]   prod;

    // Next-state, datapath and output-register logic for the three-state FSM.
    always_comb begin
        state_d  = state_q;
        mag_m_d  = mag_m_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        done_d   = 1'b0;
        mag_q_in = '0;
        sum      = '0;
        added    = '0;
        prod     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // The most negative value negates to itself, which reads
                    // correctly as its unsigned magnitude.
                    mag_m_d  = (signed_mode && m[WIDTH-1]) ? -m : m;
                    mag_q_in = (signed_mode && q[WIDTH-1]) ? -q : q;
                    neg_d    = signed_mode & (m[WIDTH-1] ^ q[WIDTH-1]);
                    acc_d    = {{(WIDTH+1){1'b0}}, mag_q_in};
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum   = acc_q[0] ? (acc_q[2*WIDTH:WIDTH] + {1'b0, mag_m_q})
                                 : acc_q[2*WIDTH:WIDTH];
                added = {sum, acc_q[WIDTH-1:0]};
                acc_d = added >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // A zero magnitude negates to zero, so a signed zero is just 0.
                prod    = acc_q[2*WIDTH-1:0];
                p_d     = neg_q ? -prod : prod;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_m_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_m_q <= mag_m_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier: a vector table at WIDTH=4, hand
// sequences for ignored/back-to-back starts and mid-operation reset, and a
// WIDTH=8 instance checked against an integer reference product.
module tb_seq_array_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, sm;
    logic [3:0]  m, q;
    logic        busy, done;
    logic [7:0]  p;

    logic        start8, sm8;
    logic [7:0]  m8, q8;
    logic        busy8, done8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sm;
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] expP;
    } vec_t;

    vec_t vecs[11];

    seq_array_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .m(m), .q(q), .busy(busy), .done(done), .p(p)
    );

    seq_array_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .m(m8), .q(q8), .busy(busy8), .done(done8), .p(p8)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Global safety net in case a bounded wait is somehow bypassed.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one WIDTH=4 op; return edges from start sample to done and
    // whether busy stayed high (done low) up to the done cycle.
    task automatic applyStimulus(input logic s, input logic [3:0] a, input logic [3:0] b,
                                 output int lat, output logic busyOk);
        int cyc;
        @(negedge clk);
        start = 1'b1; sm = s; m = a; q = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busyOk = busy && !done;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!done && !busy) busyOk = 1'b0;
        end
        if (busy) busyOk = 1'b0;
        lat = cyc - 1;
    endtask

    // Launch one WIDTH=8 op and return its latency in edges.
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
        int cyc;
        @(negedge clk);
        start8 = 1'b1; sm8 = s; m8 = a; q8 = b;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
    endtask

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    initial begin
        int lat;
        logic bok;
        int pulses;
        logic quiet;
        logic [7:0] ca[4];
        logic [7:0] cb[4];
        logic       cs[4];

        vecs[0]  = '{1'b0, 4'd3,  4'd5,  8'h0F};
        vecs[1]  = '{1'b0, 4'd15, 4'd15, 8'hE1};
        vecs[2]  = '{1'b0, 4'd0,  4'd9,  8'h00};
        vecs[3]  = '{1'b1, 4'h8,  4'h7,  8'hC8};
        vecs[4]  = '{1'b1, 4'h8,  4'h8,  8'h40};
        vecs[5]  = '{1'b1, 4'hF,  4'h0,  8'h00};
        vecs[6]  = '{1'b1, 4'hF,  4'hF,  8'h01};
        vecs[7]  = '{1'b1, 4'h3,  4'hD,  8'hF7};
        vecs[8]  = '{1'b0, 4'h8,  4'h7,  8'h38};
        vecs[9]  = '{1'b1, 4'h7,  4'h7,  8'h31};
        vecs[10] = '{1'b0, 4'hD,  4'h2,  8'h1A};

        rst_n = 1'b0; start = 1'b0; sm = 1'b0; m = '0; q = '0;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;

        #3;
        checkOutput("reset_p",    p,    8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_p8",   p8,   16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", busy, 1'b0);

        $display("[TB] WIDTH=4 vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sm, vecs[i].m, vecs[i].q, lat, bok);
            checkOutput($sformatf("vec%0d_p", i), p, vecs[i].expP);
            checkOutput($sformatf("vec%0d_latency", i), lat, 5);
            checkOutput($sformatf("vec%0d_busy", i), bok, 1'b1);
            if (i == 0) begin
                @(negedge clk);
                checkOutput("hold_done", done, 1'b0);
                @(negedge clk);
                checkOutput("hold_p", p, 8'h0F);
            end
        end

        $display("[TB] ignored start and back-to-back start");
        @(negedge clk);
        start = 1'b1; sm = 1'b0; m = 4'd2; q = 4'd3;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        lat++;
        start = 1'b1; m = 4'd7; q = 4'd7;
        @(negedge clk);
        lat++;
        start = 1'b0;
        pulses = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignore_p", p, 8'h06);
        checkOutput("ignore_latency", lat - 1, 5);
        start = 1'b1; m = 4'd7; q = 4'd7;
        @(negedge clk);
        start = 1'b0;
        checkOutput("single_done", done, 1'b0);
        checkOutput("b2b_busy", busy, 1'b1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b_p", p, 8'h31);
        checkOutput("b2b_latency", lat - 1, 5);

        $display("[TB] reset in the middle of an operation");
        @(negedge clk);
        start = 1'b1; sm = 1'b0; m = 4'd9; q = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_p",    p,    8'h00);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy || p !== 8'h00) quiet = 1'b0;
        end
        checkOutput("postreset_done_count", pulses, 0);
        checkOutput("postreset_quiet", quiet, 1'b1);
        applyStimulus(1'b0, 4'd9, 4'd9, lat, bok);
        checkOutput("postreset_p", p, 8'h51);
        checkOutput("postreset_latency", lat, 5);

        $display("[TB] WIDTH=8 corners and random vectors");
        cs[0] = 1'b1; ca[0] = 8'h80; cb[0] = 8'h80;
        cs[1] = 1'b0; ca[1] = 8'hFF; cb[1] = 8'hFF;
        cs[2] = 1'b1; ca[2] = 8'h80; cb[2] = 8'h7F;
        cs[3] = 1'b1; ca[3] = 8'hFF; cb[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            run8(cs[i], ca[i], cb[i], lat);
            checkOutput($sformatf("w8_corner%0d_p", i), p8, ref8(cs[i], ca[i], cb[i]));
            checkOutput($sformatf("w8_corner%0d_latency", i), lat, 9);
        end
        for (int i = 0; i < 300; i++) begin
            logic s;
            logic [7:0] a, b;
            s = i[0];
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run8(s, a, b, lat);
            checkOutput($sformatf("w8_rand%0d_p(s=%0d a=%0h b=%0h)", i, s, a, b), p8, ref8(s, a, b));
            checkOutput($sformatf("w8_rand%0d_latency", i), lat, 9);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
